// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC operand path.
package mac_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} loader_state_e;

  localparam int MAC_WIDTH_DEF = 32;
  localparam int MAC_TAPS_DEF  = 4;

  // Index width for n entries; at least one bit so single-entry ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mac_tap_delay_line.sv
// TAPS-deep sample delay line: d[0] is the newest sample; indexed combinational read.
module mac_tap_delay_line
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF,
  parameter int TAPS  = MAC_TAPS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic [WIDTH-1:0]         din,
  input  logic [clog2(TAPS)-1:0]   rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  logic [TAPS-1:0][WIDTH-1:0] d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        d <= '0;
    else if (shift_en) d <= {d[TAPS-2:0], din};
  end

  assign rd_data = d[rd_idx];

endmodule

// File: rtl/mac_tap_loader.sv
// Feeds TAPS {signal, coeff} pairs per accepted sample into the MAC operand FIFO pair.
// Optional MAC_TAP_LOADER_SKIPZERO_EN: taps whose coefficient is zero are skipped.
module mac_tap_loader
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF,
  parameter int TAPS  = MAC_TAPS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [clog2(TAPS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  output logic                   cfg_err,
  input  logic                   sample_valid,
  input  logic [WIDTH-1:0]       sample_data,
  output logic                   sample_ready,
  input  logic                   fifo_full,
  output logic                   push,
  output logic [WIDTH-1:0]       signal_data,
  output logic [WIDTH-1:0]       coeff_data,
  output logic                   frame_done
);

  localparam int            AW   = clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  loader_state_e              state, state_nxt;
  logic [AW-1:0]              tap_idx;
  logic [TAPS-1:0][WIDTH-1:0] coef;
  logic                       accept, adv, skip, last, addr_ok, cfg_ok;
  logic [31:0]                addr_ext;

  assign accept = sample_valid && sample_ready;
  assign last   = (tap_idx == LAST);

  // Widen before comparing so non-power-of-two TAPS range checks stay meaningful.
  assign addr_ext = 32'(cfg_addr);
  assign addr_ok  = (addr_ext < 32'(TAPS));
  assign cfg_ok   = cfg_we && (state == IDLE) && addr_ok;

  mac_tap_delay_line #(.WIDTH(WIDTH), .TAPS(TAPS)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (sample_data),
    .rd_idx   (tap_idx),
    .rd_data  (signal_data)
  );

  assign coeff_data = coef[tap_idx];

`ifdef MAC_TAP_LOADER_SKIPZERO_EN
  assign skip = (coeff_data == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = BURST;
      BURST:   if (adv && last) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // A skipped tap advances even under fifo_full since nothing is written.
  always_comb begin
    sample_ready = 1'b0;
    push         = 1'b0;
    adv          = 1'b0;
    case (state)
      IDLE:  sample_ready = 1'b1;
      BURST: begin
        push = !skip && !fifo_full;
        adv  = push || skip;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tap_idx <= '0;
    else if (accept)        tap_idx <= '0;
    else if (adv && !last)  tap_idx <= tap_idx + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      coef <= '0;
    else if (cfg_ok) coef[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= adv && last;
      cfg_err    <= cfg_we && !cfg_ok;
    end
  end

endmodule

// File: tb/tb_mac_tap_loader.sv
// Bench for mac_tap_loader: vector table plus scoreboard of expected push pairs.
module tb_mac_tap_loader;
  import mac_pkg::*;

  localparam int W  = 32;
  localparam int T  = 4;
  localparam int AW = 2;
`ifdef MAC_TAP_LOADER_SKIPZERO_EN
  localparam bit SKIPZ = 1'b1;
`else
  localparam bit SKIPZ = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_we = 1'b0, cfg_err;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          sample_valid = 1'b0, sample_ready;
  logic [W-1:0]  sample_data = '0;
  logic          fifo_full = 1'b0, push, frame_done;
  logic [W-1:0]  signal_data, coeff_data;

  logic          c3_we = 1'b0, c3_err, c3_ready, c3_push, c3_done;
  logic [1:0]    c3_addr = '0;
  logic [W-1:0]  c3_sig, c3_coef;

  always #5 clk = ~clk;

  mac_tap_loader #(.WIDTH(W), .TAPS(T)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .fifo_full(fifo_full), .push(push),
    .signal_data(signal_data), .coeff_data(coeff_data), .frame_done(frame_done)
  );

  // Three-tap instance so an out-of-range coefficient index is expressible.
  mac_tap_loader #(.WIDTH(W), .TAPS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(c3_we), .cfg_addr(c3_addr), .cfg_data(32'd5),
    .cfg_err(c3_err), .sample_valid(1'b0), .sample_data(32'd0),
    .sample_ready(c3_ready), .fifo_full(1'b0), .push(c3_push),
    .signal_data(c3_sig), .coeff_data(c3_coef), .frame_done(c3_done)
  );

  typedef struct { logic [W-1:0] s; logic [W-1:0] c; } pair_t;
  typedef struct { logic [W-1:0] sample; logic [W-1:0] sig [T]; logic [W-1:0] cf [T]; } vec_t;

  pair_t        exp_q [$];
  pair_t        mon_p;
  logic [W-1:0] md [T];
  logic [W-1:0] mcoef [T];
  vec_t         vecs [5];
  int nvec = 0, nerr = 0, cyc = 0;
  int push_cnt = 0, frame_cnt = 0, acc_cyc = 0, stall_extra = 0;
  bit burst_open = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (push) begin
      push_cnt++;
      chk("push_under_full", fifo_full, 0);
      chk("push_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_p = exp_q.pop_front();
        chk("signal_data", signal_data, mon_p.s);
        chk("coeff_data", coeff_data, mon_p.c);
      end
    end
    if (frame_done) begin
      frame_cnt++;
      chk("frame_expected", burst_open, 1);
      if (burst_open) chk("frame_cycle", cyc, acc_cyc + T + stall_extra);
      burst_open = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] data, input bit gen);
    int n = 0;
    sample_valid = 1'b1;
    sample_data  = data;
    while (!sample_ready && n < 50) begin step(); n++; end
    chk("accept_timeout", n < 50, 1);
    step();
    for (int k = T - 1; k > 0; k--) md[k] = md[k-1];
    md[0] = data;
    if (gen)
      for (int k = 0; k < T; k++)
        if (!SKIPZ || mcoef[k] != 0) exp_q.push_back('{s: md[k], c: mcoef[k]});
    acc_cyc     = cyc;
    stall_extra = 0;
    burst_open  = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || burst_open) && n < 200) begin step(); n++; end
    chk("drain_timeout", n < 200, 1);
  endtask

  task automatic cfg_write(input int addr, input logic [W-1:0] data, input bit exp_err);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
    step();
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
    if (!exp_err) mcoef[addr] = data;
    step();
    chk("cfg_err_pulse", cfg_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pc0, fc0, prev;
    for (int k = 0; k < T; k++) begin md[k] = '0; mcoef[k] = '0; end
    // coef = {1,2,3,4}; delay line starts empty after reset
    vecs[0] = '{sample: 10, sig: '{10,  0,  0,  0}, cf: '{1, 2, 3, 4}};
    vecs[1] = '{sample: 20, sig: '{20, 10,  0,  0}, cf: '{1, 2, 3, 4}};
    vecs[2] = '{sample: 30, sig: '{30, 20, 10,  0}, cf: '{1, 2, 3, 4}};
    vecs[3] = '{sample: 40, sig: '{40, 30, 20, 10}, cf: '{1, 2, 3, 4}};
    vecs[4] = '{sample: 50, sig: '{50, 40, 30, 20}, cf: '{1, 2, 3, 4}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_push", push, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    step();
    chk("rst_sample_ready", sample_ready, 1);
    chk("rst_push_after", push, 0);

    for (int k = 0; k < T; k++) cfg_write(k, k + 1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].sample, 1'b0);
      sample_valid = 1'b0;
      for (int k = 0; k < T; k++) exp_q.push_back('{s: vecs[i].sig[k], c: vecs[i].cf[k]});
      drain();
    end

    // Backpressure: stall three cycles after the second push
    send(60, 1'b1);
    sample_valid = 1'b0;
    step();
    step();
    fifo_full   = 1'b1;
    stall_extra = 3;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_push", push, 0);
      chk("stall_signal", signal_data, md[2]);
      chk("stall_coeff", coeff_data, mcoef[2]);
      step();
    end
    fifo_full = 1'b0;
    drain();

    // Config write during a burst is refused
    send(70, 1'b1);
    sample_valid = 1'b0;
    cfg_write(0, 99, 1'b1);
    drain();
    send(80, 1'b1);
    sample_valid = 1'b0;
    drain();

    c3_we = 1'b1; c3_addr = 2'd3;
    step();
    c3_we = 1'b0;
    chk("cfg_err_addr_range", c3_err, 1);
    step();
    chk("cfg_err_addr_pulse", c3_err, 0);
    c3_we = 1'b1; c3_addr = 2'd2;
    step();
    c3_we = 1'b0;
    chk("cfg_err_addr_ok", c3_err, 0);

    // Back-to-back samples with valid held high
    pc0 = push_cnt;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(100 + i, 1'b1);
      if (i > 0) chk("b2b_gap", acc_cyc - prev, T + 1);
      prev = acc_cyc;
    end
    sample_valid = 1'b0;
    drain();
    chk("b2b_pushes", push_cnt - pc0, 8 * T);

    // Reset in the middle of a burst, then read back the cleared state
    send(5, 1'b1);
    sample_valid = 1'b0;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    burst_open = 1'b0;
    for (int k = 0; k < T; k++) begin md[k] = '0; mcoef[k] = '0; end
    #1;
    chk("midrst_push", push, 0);
    chk("midrst_frame_done", frame_done, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready", sample_ready, 1);
    fc0 = frame_cnt;
    send(0, 1'b1);
    sample_valid = 1'b0;
    drain();
    chk("readback_frames", frame_cnt - fc0, 1);

`ifdef MAC_TAP_LOADER_SKIPZERO_EN
    cfg_write(0, 5, 1'b0);
    cfg_write(1, 0, 1'b0);
    cfg_write(2, 0, 1'b0);
    cfg_write(3, 7, 1'b0);
    pc0 = push_cnt; fc0 = frame_cnt;
    send(9, 1'b1);
    sample_valid = 1'b0;
    drain();
    chk("skip_pushes", push_cnt - pc0, 2);
    chk("skip_frames", frame_cnt - fc0, 1);
    for (int k = 0; k < T; k++) cfg_write(k, 0, 1'b0);
    pc0 = push_cnt; fc0 = frame_cnt;
    send(11, 1'b1);
    sample_valid = 1'b0;
    drain();
    chk("allzero_pushes", push_cnt - pc0, 0);
    chk("allzero_frames", frame_cnt - fc0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
